scram_ctrl_128b: RTL and testbench
==================================

Name: scram_ctrl_128b

Overview:
- Per-block sequencer for the 128b/130b scrambler datapath.
- Tracks 130b block framing from the sync header and the ordered-set identifier symbol.
- For each symbol, drives the scrambler's enable pair: en_scram[1] advances the LFSR, en_scram[0] applies the XOR.
- Drives the LFSR's active-low reset rst_mod when an EIEOS completes or on explicit reinit.
- Sits between the block framer and scrambler_23b in the Gen3 transmit path.

Parameters:
SYMS_PER_BLK, 16, symbols per 128b block; sym_idx wraps at this value
EIEOS_ID, 8'h00, ordered-set identifier of EIEOS
SKP_ID, 8'hAA, ordered-set identifier of SKP OS
IDX_W, 4, width of sym_idx (clog2 of SYMS_PER_BLK)

Ports:
clk_1G  input  1  symbol clock, one symbol per cycle when sym_valid
rst_1G  input  1  synchronous, active-high reset
blk_start  input  1  marks sym_in as symbol 0 of a new block; sync_hdr is valid in the same cycle
sync_hdr  input  2  2'b10 = data block, 2'b01 = ordered-set block
sym_valid  input  1  symbol present on sym_in this cycle
sym_in  input  8  current symbol, used only to classify the OS identifier at symbol 0
scram_disable  input  1  training "disable scrambling" bit
lfsr_reinit  input  1  single-cycle request to reseed the LFSR
en_scram  output  2  [1] LFSR advance, [0] XOR apply; registered
rst_mod  output  1  active-low LFSR reset to the scrambler; registered
sym_idx  output  IDX_W  index of the symbol qualified by en_scram
os_type  output  2  0 data, 1 EIEOS, 2 SKP, 3 other OS; held for the whole block
blk_done  output  1  one-cycle pulse with the last symbol of a block
hdr_err  output  1  one-cycle pulse on an invalid sync header
frame_err  output  1  one-cycle pulse on a blk_start before the current block ends

Behaviour:
- Reset (rst_1G=1 at a clk_1G edge) sets the following:
  - state=IDLE; en_scram=2'b00; rst_mod=0; sym_idx=0; os_type=0; blk_done=0; hdr_err=0; frame_err=0.
  - After reset release, rst_mod returns to 1 on the next edge.
- All outputs are registered. Controls for an accepted symbol appear exactly 1 clk_1G cycle later, aligned with the scrambler's registered copy of that symbol.
- States: IDLE, DATA, OS_EIEOS, OS_SKP, OS_OTHER, BAD.
- IDLE:
  - Ignores sym_valid unless blk_start is also high.
  - On blk_start&sym_valid, decodes the block type:
    - sync_hdr=10 -> DATA.
    - sync_hdr=01 and sym_in==EIEOS_ID -> OS_EIEOS.
    - sync_hdr=01 and sym_in==SKP_ID -> OS_SKP.
    - sync_hdr=01, any other sym_in -> OS_OTHER.
    - sync_hdr=00 or 11 -> BAD, and hdr_err pulses.
  - The decoded symbol is counted as sym_idx 0.
- Per-symbol rules (x = !scram_disable):
  - DATA: every symbol gets en_scram={1,x}.
  - OS_OTHER: symbol 0 gets {1,0}; symbols 1..15 get {1,x}.
  - OS_SKP: every symbol gets {0,0}; the LFSR is frozen.
  - OS_EIEOS: every symbol gets {0,0}. On the cycle carrying symbol 15's controls, rst_mod=0 for exactly 1 cycle, so the LFSR reseeds to its standard seed before the next block.
  - BAD: every symbol gets {0,0}.
- scram_disable gates only en_scram[0]; the LFSR still advances.
- Counting:
  - The internal counter increments only on sym_valid. A sym_valid=0 cycle outputs en_scram=00 and holds the counter.
  - At count SYMS_PER_BLK-1 with sym_valid, blk_done pulses and the state returns to IDLE.
  - A blk_start arriving in the same cycle as the last symbol is a frame_err, not a back-to-back block. The next block's blk_start must come at least 1 cycle after the last symbol.
- Mid-block blk_start (count not yet at the last symbol):
  - frame_err pulses.
  - The current block is abandoned with no blk_done.
  - The new block is decoded from this cycle's sync_hdr/sym_in, exactly as from IDLE.
- lfsr_reinit:
  - Forces rst_mod=0 for 1 cycle, 1 cycle after the request.
  - en_scram for that cycle is still driven by the rules above, but the LFSR reset has priority.
  - If lfsr_reinit coincides with the EIEOS last symbol, rst_mod=0 once, not twice.
- Reset mid-block: the block is dropped and no blk_done is issued.

Test Plan:
- Data block: reset, then blk_start, sync_hdr=10, 16 valid symbols -> 16 cycles of en_scram=11 starting 1 cycle later; sym_idx 0..15; blk_done with idx 15; rst_mod stays 1.
- TS1 OS: blk_start, sync_hdr=01, sym_in=8'h1E, then 15 symbols -> en_scram=10 at idx0, 11 at idx1..15, os_type=3. Repeat with scram_disable=1 -> idx1..15 are 10.
- EIEOS: sync_hdr=01, sym_in=8'h00, 16 symbols -> en_scram=00 throughout; rst_mod=0 only on the idx15 cycle; os_type=1; the following data block restarts from the LFSR seed (check scrambled output against the golden first byte).
- SKP with gaps: sync_hdr=01, sym_in=8'hAA, sym_valid deasserted at symbols 5 and 9 for 1 cycle each -> en_scram=00 everywhere; blk_done after the 16th valid symbol (cycle 18).
- Errors: blk_start at idx7 of a data block -> frame_err pulse, no blk_done, new block idx0 next cycle. sync_hdr=11 -> hdr_err, 16 symbols of en_scram=00.
- lfsr_reinit pulsed mid-data-block at idx4 -> rst_mod=0 for exactly 1 cycle, 1 cycle later; en_scram stays 11; counting is uninterrupted.

Source files
------------

// File: rtl/scram_ctrl_128b.sv
// Per-block sequencer for the 128b/130b scrambler: tracks block framing and
// drives the LFSR advance/apply enables and the LFSR's active-low reseed.
module scram_ctrl_128b #(
    parameter int unsigned SYMS_PER_BLK = 16,
    parameter logic [7:0]  EIEOS_ID     = 8'h00,
    parameter logic [7:0]  SKP_ID       = 8'hAA,
    parameter int unsigned IDX_W        = 4
) (
    input  logic             clk_1G,
    input  logic             rst_1G,
    input  logic             blk_start,
    input  logic [1:0]       sync_hdr,
    input  logic             sym_valid,
    input  logic [7:0]       sym_in,
    input  logic             scram_disable,
    input  logic             lfsr_reinit,
    output logic [1:0]       en_scram,
    output logic             rst_mod,
    output logic [IDX_W-1:0] sym_idx,
    output logic [1:0]       os_type,
    output logic             blk_done,
    output logic             hdr_err,
    output logic             frame_err
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DATA  = 3'd1;
    localparam logic [2:0] ST_EIEOS = 3'd2;
    localparam logic [2:0] ST_SKP   = 3'd3;
    localparam logic [2:0] ST_OTHER = 3'd4;
    localparam logic [2:0] ST_BAD   = 3'd5;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMS_PER_BLK - 1);

    logic [2:0]       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [1:0]       en_scram_q, en_scram_d;
    logic             rst_mod_q, rst_mod_d;
    logic [IDX_W-1:0] sym_idx_q, sym_idx_d;
    logic [1:0]       os_type_q, os_type_d;
    logic             blk_done_q, blk_done_d;
    logic             hdr_err_q, hdr_err_d;
    logic             frame_err_q, frame_err_d;

    logic [2:0]       dec_state;
    logic [1:0]       dec_os;
    logic             start_new;
    logic             sym_act;
    logic [2:0]       act_state;
    logic [IDX_W-1:0] act_idx;

    // Block type decode from the header and the OS identifier at symbol 0.
    always_comb begin
        dec_state = ST_BAD;
        dec_os    = 2'd0;
        case (sync_hdr)
            2'b10: begin
                dec_state = ST_DATA;
                dec_os    = 2'd0;
            end
            2'b01: begin
                if (sym_in == EIEOS_ID) begin
                    dec_state = ST_EIEOS;
                    dec_os    = 2'd1;
                end else if (sym_in == SKP_ID) begin
                    dec_state = ST_SKP;
                    dec_os    = 2'd2;
                end else begin
                    dec_state = ST_OTHER;
                    dec_os    = 2'd3;
                end
            end
            default: begin
                dec_state = ST_BAD;
                dec_os    = 2'd0;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        en_scram_d  = 2'b00;
        rst_mod_d   = !lfsr_reinit;
        sym_idx_d   = sym_idx_q;
        os_type_d   = os_type_q;
        blk_done_d  = 1'b0;
        hdr_err_d   = 1'b0;
        frame_err_d = 1'b0;
        start_new   = 1'b0;
        sym_act     = 1'b0;
        act_state   = state_q;
        act_idx     = cnt_q;

        if (sym_valid) begin
            if (state_q == ST_IDLE) begin
                start_new = blk_start;
            end else if (blk_start && (cnt_q != LAST_IDX)) begin
                frame_err_d = 1'b1;
                start_new   = 1'b1;
            end else begin
                // A blk_start on the last symbol only flags; the block still completes.
                sym_act     = 1'b1;
                frame_err_d = blk_start;
                if (cnt_q == LAST_IDX) begin
                    blk_done_d = 1'b1;
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        if (start_new) begin
            sym_act   = 1'b1;
            act_state = dec_state;
            act_idx   = '0;
            state_d   = dec_state;
            cnt_d     = IDX_W'(1);
            os_type_d = dec_os;
            hdr_err_d = (dec_state == ST_BAD);
        end

        if (sym_act) begin
            sym_idx_d = act_idx;
            case (act_state)
                ST_DATA:  en_scram_d = {1'b1, !scram_disable};
                ST_OTHER: en_scram_d = {1'b1, !scram_disable && (act_idx != '0)};
                ST_EIEOS: begin
                    if (act_idx == LAST_IDX) begin
                        rst_mod_d = 1'b0;
                    end
                end
                default:  en_scram_d = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk_1G) begin
        if (rst_1G) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            en_scram_q  <= 2'b00;
            rst_mod_q   <= 1'b0;
            sym_idx_q   <= '0;
            os_type_q   <= 2'd0;
            blk_done_q  <= 1'b0;
            hdr_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            en_scram_q  <= en_scram_d;
            rst_mod_q   <= rst_mod_d;
            sym_idx_q   <= sym_idx_d;
            os_type_q   <= os_type_d;
            blk_done_q  <= blk_done_d;
            hdr_err_q   <= hdr_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign en_scram  = en_scram_q;
    assign rst_mod   = rst_mod_q;
    assign sym_idx   = sym_idx_q;
    assign os_type   = os_type_q;
    assign blk_done  = blk_done_q;
    assign hdr_err   = hdr_err_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_scram_ctrl_128b.sv
// Self-checking bench for scram_ctrl_128b: directed block sequences plus
// randomized traffic, compared every cycle against a block-level reference model.
module tb_scram_ctrl_128b;

    localparam int N = 16;

    logic       clk_1G = 1'b0;
    logic       rst_1G = 1'b1;
    logic       blk_start = 1'b0;
    logic [1:0] sync_hdr = 2'b00;
    logic       sym_valid = 1'b0;
    logic [7:0] sym_in = 8'h00;
    logic       scram_disable = 1'b0;
    logic       lfsr_reinit = 1'b0;
    logic [1:0] en_scram;
    logic       rst_mod;
    logic [3:0] sym_idx;
    logic [1:0] os_type;
    logic       blk_done;
    logic       hdr_err;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: which block we are inside and how many symbols it has seen.
    bit   m_active;
    int   m_kind;  // 0 data, 1 EIEOS, 2 SKP, 3 other OS, 4 bad header
    int   m_cnt;
    int   e_en, e_rst, e_idx, e_os, e_done, e_herr, e_ferr;

    scram_ctrl_128b #(
        .SYMS_PER_BLK(16),
        .EIEOS_ID(8'h00),
        .SKP_ID(8'hAA),
        .IDX_W(4)
    ) dut (
        .clk_1G(clk_1G),
        .rst_1G(rst_1G),
        .blk_start(blk_start),
        .sync_hdr(sync_hdr),
        .sym_valid(sym_valid),
        .sym_in(sym_in),
        .scram_disable(scram_disable),
        .lfsr_reinit(lfsr_reinit),
        .en_scram(en_scram),
        .rst_mod(rst_mod),
        .sym_idx(sym_idx),
        .os_type(os_type),
        .blk_done(blk_done),
        .hdr_err(hdr_err),
        .frame_err(frame_err)
    );

    always #5 clk_1G = ~clk_1G;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int classify(input logic [1:0] hdr, input logic [7:0] id);
        if (hdr == 2'b10) return 0;
        if (hdr == 2'b01) begin
            if (id == 8'h00) return 1;
            if (id == 8'hAA) return 2;
            return 3;
        end
        return 4;
    endfunction

    // Scrambler enable pair for one symbol of a block of the given kind.
    function automatic int en_rule(input int kind, input int idx, input bit dis);
        case (kind)
            0:       return dis ? 2 : 3;
            3:       return (idx == 0 || dis) ? 2 : 3;
            default: return 0;
        endcase
    endfunction

    function automatic void model_step();
        bit take;
        e_en = 0; e_done = 0; e_herr = 0; e_ferr = 0;
        if (rst_1G) begin
            m_active = 0; m_cnt = 0; m_kind = 0;
            e_rst = 0; e_idx = 0; e_os = 0;
            return;
        end
        e_rst = lfsr_reinit ? 0 : 1;
        if (!sym_valid) return;
        take = 0;
        if (blk_start && (!m_active || m_cnt < N - 1)) begin
            e_ferr   = m_active ? 1 : 0;
            m_kind   = classify(sync_hdr, sym_in);
            m_active = 1;
            m_cnt    = 0;
            e_os     = (m_kind == 4) ? 0 : m_kind;
            e_herr   = (m_kind == 4) ? 1 : 0;
            take     = 1;
        end else if (m_active) begin
            e_ferr = blk_start ? 1 : 0;
            take   = 1;
        end
        if (take) begin
            e_idx = m_cnt;
            e_en  = en_rule(m_kind, m_cnt, scram_disable);
            if (m_cnt == N - 1) begin
                e_done   = 1;
                m_active = 0;
                if (m_kind == 1) e_rst = 0;
            end
            m_cnt++;
        end
    endfunction

    // One clock: model consumes the inputs seen at the edge, outputs are sampled 1ns later.
    task automatic step();
        @(posedge clk_1G);
        model_step();
        #1;
        check_eq("en_scram",  en_scram,  e_en);
        check_eq("rst_mod",   rst_mod,   e_rst);
        check_eq("sym_idx",   sym_idx,   e_idx);
        check_eq("os_type",   os_type,   e_os);
        check_eq("blk_done",  blk_done,  e_done);
        check_eq("hdr_err",   hdr_err,   e_herr);
        check_eq("frame_err", frame_err, e_ferr);
    endtask

    task automatic drive(input bit bs, input logic [1:0] hdr, input logic [7:0] sym,
                         input bit sv, input bit rein);
        blk_start   = bs;
        sync_hdr    = hdr;
        sym_in      = sym;
        sym_valid   = sv;
        lfsr_reinit = rein;
        step();
    endtask

    // Sends one 16-symbol block; gap_a/gap_b insert an idle cycle before that symbol,
    // abort_at restarts a data block mid-way. Reports the cycle that showed blk_done.
    task automatic send_block(input logic [1:0] hdr, input logic [7:0] id,
                              input int gap_a, input int gap_b, input int reinit_at,
                              input int abort_at, input bit bs_last, output int done_cyc);
        int cyc;
        cyc = 0;
        done_cyc = -1;
        for (int i = 0; i < N; i++) begin
            if (i == gap_a || i == gap_b) begin
                drive(0, hdr, 8'h55, 0, 0);
                cyc++;
                if (blk_done) done_cyc = cyc;
            end
            if (i == abort_at) begin
                drive(1, 2'b10, 8'h3C, 1, 0);
                cyc++;
                if (blk_done) done_cyc = cyc;
                for (int j = 1; j < N; j++) begin
                    drive(0, 2'b10, 8'($urandom), 1, 0);
                    cyc++;
                    if (blk_done) done_cyc = cyc;
                end
                break;
            end
            drive((i == 0) || (bs_last && i == N - 1), (i == 0) ? hdr : 2'b10,
                  (i == 0) ? id : 8'($urandom), 1, i == reinit_at);
            cyc++;
            if (blk_done) done_cyc = cyc;
        end
        drive(0, 2'b00, 8'h00, 0, 0);
    endtask

    initial begin
        int dc;
        int r;
        logic [7:0] ids [4];
        ids[0] = 8'h00; ids[1] = 8'hAA; ids[2] = 8'h1E; ids[3] = 8'h2D;

        rst_1G = 1;
        drive(0, 2'b00, 8'h00, 0, 0);
        drive(1, 2'b10, 8'h00, 1, 1);
        rst_1G = 0;
        drive(0, 2'b00, 8'h00, 0, 0);

        send_block(2'b10, 8'h47, -1, -1, -1, -1, 0, dc);
        check_eq("data_done_cycle", dc, 16);
        send_block(2'b01, 8'h1E, -1, -1, -1, -1, 0, dc);
        scram_disable = 1;
        send_block(2'b01, 8'h1E, -1, -1, -1, -1, 0, dc);
        scram_disable = 0;
        send_block(2'b01, 8'h00, -1, -1, -1, -1, 0, dc);
        send_block(2'b10, 8'h12, -1, -1, -1, -1, 0, dc);
        send_block(2'b01, 8'hAA, 5, 9, -1, -1, 0, dc);
        check_eq("skp_gap_done_cycle", dc, 18);
        send_block(2'b10, 8'h99, -1, -1, -1, 7, 0, dc);
        check_eq("abort_done_cycle", dc, 23);
        send_block(2'b11, 8'h10, -1, -1, -1, -1, 0, dc);
        send_block(2'b00, 8'h10, -1, -1, -1, -1, 0, dc);
        send_block(2'b10, 8'h20, -1, -1, 4, -1, 0, dc);
        send_block(2'b01, 8'h00, -1, -1, 15, -1, 0, dc);
        send_block(2'b10, 8'h30, -1, -1, -1, -1, 1, dc);
        send_block(2'b01, 8'h1E, -1, -1, -1, 3, 0, dc);

        // Reset in the middle of a block drops it without blk_done.
        drive(1, 2'b10, 8'h01, 1, 0);
        for (int i = 0; i < 5; i++) drive(0, 2'b10, 8'h02, 1, 0);
        rst_1G = 1;
        drive(0, 2'b10, 8'h02, 1, 0);
        rst_1G = 0;
        for (int i = 0; i < 12; i++) drive(0, 2'b10, 8'h02, 1, 0);

        for (int c = 0; c < 4000; c++) begin
            logic [1:0] hdr;
            bit bs;
            r = $urandom_range(0, 9);
            hdr = (r < 5) ? 2'b10 : (r < 9) ? 2'b01 : (($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00);
            if (!m_active)          bs = ($urandom_range(0, 2) == 0);
            else if (m_cnt == N-1)  bs = ($urandom_range(0, 9) == 0);
            else                    bs = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 7) == 0) scram_disable = ~scram_disable;
            rst_1G = ($urandom_range(0, 499) == 0);
            drive(bs, hdr, ($urandom_range(0, 3) == 3) ? 8'($urandom) : ids[$urandom_range(0, 3)],
                  $urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
        end
        rst_1G = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
